// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM output projection stage.
// Holds the fixed-point format, dot-product length, derived widths,
// the controller state encoding and the signed saturation limits of y.
package lstm_pkg;

  localparam int WL   = 12;                  // word length of h, w, bias, y
  localparam int FL   = 8;                   // fractional bits per operand
  localparam int N    = 16;                  // hidden units per timestep
  localparam int AW   = $clog2(N);           // weight index width
  localparam int ACCW = 2*WL + $clog2(N) + 1; // overflow-free accumulator width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    BIAS = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam logic signed [WL-1:0] Y_MAX = {1'b0, {(WL-1){1'b1}}};
  localparam logic signed [WL-1:0] Y_MIN = {1'b1, {(WL-1){1'b0}}};

  localparam logic [AW-1:0] IDX_LAST = AW'(N-1);

endpackage

// File: rtl/fx_round_sat.sv
// Combinational round-half-up and clip from the accumulator format
// (ACCW bits, 2*FL fractional bits) down to a WL-bit word with FL fractional bits.
//   val_i : ACCW-bit signed value to convert
//   y_o   : rounded, saturated WL-bit result
//   sat_o : high when the rounded value did not fit and was clipped
module fx_round_sat
  import lstm_pkg::*;
(
  input  logic [ACCW-1:0] val_i,
  output logic [WL-1:0]   y_o,
  output logic            sat_o
);

  // Half an output LSB expressed in the accumulator scale.
  localparam logic signed [ACCW:0] HALF = {{(ACCW+1-FL){1'b0}}, 1'b1, {(FL-1){1'b0}}};

  logic signed [ACCW:0] r_s;
  logic signed [ACCW:0] q_s;
  logic                 fits_s;

  // One extra bit of headroom so adding HALF can never wrap.
  assign r_s = $signed({val_i[ACCW-1], val_i}) + HALF;
  assign q_s = r_s >>> FL;

  // The value fits when every bit from the y sign position upward is a sign copy.
  assign fits_s = (&q_s[ACCW:WL-1]) | ~(|q_s[ACCW:WL-1]);

  // Select the in-range value or the limit on the side of the sign.
  always_comb begin
    y_o   = q_s[WL-1:0];
    sat_o = 1'b0;
    if (fits_s) begin
      y_o   = q_s[WL-1:0];
      sat_o = 1'b0;
    end else if (q_s[ACCW]) begin
      y_o   = Y_MIN;
      sat_o = 1'b1;
    end else begin
      y_o   = Y_MAX;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/lstm_dense_head.sv
// Dense output head after the LSTM cell: y = sum(h[k]*w[k]) + bias, rounded and
// saturated to WL bits, presented on a valid/ready port.
//   clk, rst          : clock, asynchronous active-low reset
//   h_valid/h_in/h_ready : serial hidden-state stream, unit index by arrival order
//   w_we/w_addr/w_data   : weight register file write port (usable any time)
//   bias              : output bias, taken during the BIAS cycle
//   y_valid/y_out/y_ready/sat : result port, sat flags a clipped y_out
//   busy              : controller is away from IDLE
module lstm_dense_head
  import lstm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          h_valid,
  input  logic [WL-1:0] h_in,
  output logic          h_ready,
  input  logic          w_we,
  input  logic [AW-1:0] w_addr,
  input  logic [WL-1:0] w_data,
  input  logic [WL-1:0] bias,
  output logic          y_valid,
  output logic [WL-1:0] y_out,
  input  logic          y_ready,
  output logic          sat,
  output logic          busy
);

  state_e                   state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic [WL-1:0]            y_q, y_d;
  logic                     sat_q, sat_d;
  logic                     yv_q, yv_d;
  logic                     h_ready_q, h_ready_d;
  logic                     busy_q, busy_d;
  logic signed [WL-1:0]     w_q [N];

  logic                     accept_s;
  logic signed [2*WL-1:0]   h_ext_s, w_ext_s, prod_s;
  logic signed [ACCW-1:0]   prod_ext_s, bias_ext_s, rnd_in_s;
  logic [WL-1:0]            rnd_y_s;
  logic                     rnd_sat_s;

  assign accept_s = h_valid & h_ready_q;

  // Full-precision product; the weight is read before any same-cycle write lands.
  assign h_ext_s    = {{WL{h_in[WL-1]}}, h_in};
  assign w_ext_s    = {{WL{w_q[idx_q][WL-1]}}, w_q[idx_q]};
  assign prod_s     = h_ext_s * w_ext_s;
  assign prod_ext_s = {{(ACCW-2*WL){prod_s[2*WL-1]}}, prod_s};

  // Bias aligned to the product scale (2*FL fractional bits).
  assign bias_ext_s = {{(ACCW-WL-FL){bias[WL-1]}}, bias, {FL{1'b0}}};
  assign rnd_in_s   = acc_q + bias_ext_s;

  fx_round_sat u_round_sat (
    .val_i (rnd_in_s),
    .y_o   (rnd_y_s),
    .sat_o (rnd_sat_s)
  );

  // Controller next-state and datapath next values.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    y_d     = y_q;
    sat_d   = sat_q;
    yv_d    = yv_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept_s) begin
          // A vector starts from a clean sum regardless of leftover contents.
          acc_d = (state_q == IDLE) ? prod_ext_s : (acc_q + prod_ext_s);
          if (idx_q == IDX_LAST) begin
            idx_d   = {AW{1'b0}};
            state_d = BIAS;
          end else begin
            idx_d   = idx_q + AW'(1'b1);
            state_d = ACC;
          end
        end else begin
          state_d = state_q;
        end
      end
      BIAS: begin
        y_d     = rnd_y_s;
        sat_d   = rnd_sat_s;
        yv_d    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (yv_q && y_ready) begin
          yv_d    = 1'b0;
          acc_d   = {ACCW{1'b0}};
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = {AW{1'b0}};
        acc_d   = {ACCW{1'b0}};
        yv_d    = 1'b0;
      end
    endcase
    h_ready_d = (state_d == IDLE) || (state_d == ACC);
    busy_d    = (state_d != IDLE);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= {AW{1'b0}};
      acc_q     <= {ACCW{1'b0}};
      y_q       <= {WL{1'b0}};
      sat_q     <= 1'b0;
      yv_q      <= 1'b0;
      h_ready_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      sat_q     <= sat_d;
      yv_q      <= yv_d;
      h_ready_q <= h_ready_d;
      busy_q    <= busy_d;
    end
  end

  // Weight register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        w_q[k] <= {WL{1'b0}};
      end
    end else if (w_we) begin
      w_q[w_addr] <= w_data;
    end
  end

  assign h_ready = h_ready_q;
  assign y_valid = yv_q;
  assign y_out   = y_q;
  assign sat     = sat_q;
  assign busy    = busy_q;

endmodule

// File: doc/lstm_dense_head.md
Name: lstm_dense_head

Overview:
- Output projection stage directly downstream of the LSTM cell; consumes the serial h_new stream, one hidden unit per accepted beat.
- Computes y = sum(h[k]*w[k], k=0..N-1) + bias in signed fixed point, then rounds and saturates to WL bits.
- Presents y on a valid/ready output port to the next consumer (classifier, host readout).
- Holds N programmable weights in a small register file, writable at any time.

Parameters:
- WL, 12, word length of h, weights, bias and y (signed two's complement).
- FL, 8, fractional bits of every WL-bit operand; the product carries 2*FL fractional bits.
- N, 16, hidden units per timestep (dot-product length).
- AW, $clog2(N), weight address / index width.
- ACCW, 2*WL+$clog2(N)+1, accumulator width; this width cannot overflow.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- h_valid  in  1  h_in holds a valid hidden-state word.
- h_in  in  WL  hidden-state word; unit index is implied by arrival order.
- h_ready  out  1  block accepts h_in this cycle.
- w_we  in  1  weight write enable.
- w_addr  in  AW  weight index.
- w_data  in  WL  weight value.
- bias  in  WL  output bias, sampled in the BIAS state.
- y_valid  out  1  y_out and sat are valid.
- y_out  out  WL  rounded, saturated result.
- y_ready  in  1  downstream accepts y_out.
- sat  out  1  y_out was clipped; qualified by y_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, idx=0, acc=0, all weights=0. Outputs: y_valid=0, y_out=0, sat=0, busy=0, h_ready=1 once reset is released.
- States:
  - IDLE: h_ready=1. On accept (h_valid && h_ready): acc <= h_in*w[0], idx <= 1, go to ACC. If N=1, go straight to BIAS.
  - ACC: h_ready=1. On accept: acc <= acc + h_in*w[idx], idx <= idx+1. On the accept with idx=N-1: idx <= 0, go to BIAS. With no accept: hold; gaps of any length are legal.
  - BIAS: h_ready=0, one cycle.
    - r = acc + (sext(bias) <<< FL) + (1 <<< (FL-1)); round half up.
    - q = r >>> FL (arithmetic shift).
    - Saturate q to [-2^(WL-1), 2^(WL-1)-1]; sat=1 if clipped.
    - Register y_out and sat; y_valid <= 1; go to OUT.
  - OUT: h_ready=0. Hold y_out, sat and y_valid stable until y_ready=1. On y_valid && y_ready: y_valid <= 0, acc <= 0, go to IDLE. y_ready=0 stalls indefinitely.
- Latency: the cycle after the last accept is BIAS, and y_valid rises on the following edge, i.e. 2 edges after the final accept edge. Minimum period between results is N+2 cycles.
- Product is full-precision 2*WL signed and sign-extended to ACCW; no truncation until the final round step.
- Weight writes are register writes on the clock edge. A write to w[idx] in the same cycle as an accept of unit idx uses the old weight (read before write). Writes during OUT affect only the next vector.
- h_valid while h_ready=0 (BIAS/OUT): the word is not consumed; upstream must hold it.
- bias may change at any time; only its value during the BIAS cycle matters.
- rst asserted mid-vector discards the partial sum and all weights; the first accept after reset is unit 0.
- The idx wrap from N-1 to 0 is unconditional; no extra words are absorbed into a vector.

Decomposition:
- Shared package lstm_pkg:
  - WL/FL/N defaults and the derived AW/ACCW.
  - State enum {IDLE, ACC, BIAS, OUT}.
  - Signed saturation limit constants.
- Sub-module fx_round_sat (ACCW in, WL out, sat flag):
  - Purely combinational: round-half-up plus clip.
  - Reusable by the network stage.
- Weight register file and MAC stay inline.

Test Plan (WL=12, FL=8, N=16; 1.0 = 256):
- Unity sum: all w=256, h=16 ×16 beats, bias=0 -> y_out=256, sat=0, y_valid exactly 2 cycles after the 16th accept.
- Rounding: w[0]=128, other w=0, h=1 then 15 zeros, bias=0 -> r = 128+128 = 256, y_out=1. Negative case h=-1 -> y_out=0 (round half up toward +inf).
- Saturation: all w=2047, h=2047 ×16 -> y_out=2047, sat=1. With w=-2048, h=2047 -> y_out=-2048, sat=1.
- Bias plus backpressure: w=0, bias=-300, y_ready low for 10 cycles -> y_out=-300 held stable, h_ready=0 throughout, h_valid not consumed; one cycle after y_ready rises, state=IDLE and h_ready=1.
- Gaps and weight write collision:
  - Random h_valid gaps give the same result as the gap-free run.
  - Writing w[3]=0 in the same cycle unit 3 is accepted (old w[3]=256, h=256) -> that term contributes 256.
- Reset mid-vector: assert rst after 7 accepts -> y_valid=0, busy=0, weights=0. A full vector of h=100 then gives y_out=0.
